riscv_multicycle_controller: RTL and testbench
==============================================

Name: riscv_multicycle_controller

Overview:
Parametrised control unit for the multi-cycle RV32I datapath, the successor to the single-cycle controller. One FSM sequences fetch, decode, execute, memory and writeback over several cycles through a shared ALU and a single unified memory port. A ready handshake stalls the FSM while memory is busy. Unsupported opcodes drive the FSM into a sticky trap state.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored, memory states last exactly 1 cycle
SUPPORT_JALR, 1, 1: decode jalr (op 1100111); 0: jalr is illegal
FULL_BRANCH, 1, 1: decode beq/bne/blt/bge; 0: only beq, other funct3 are illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  7  instruction[6:0] from IR
funct3  in  3  instruction[14:12]
funct7  in  1  instruction[30]
zero  in  1  ALU result == 0
alu_neg  in  1  ALU result[31]; for blt/bge the datapath supplies the signed-less-than flag here
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access active
mem_write  out  1  store strobe, valid only with mem_req
adr_src  out  1  0: address = PC; 1: address = ALUOut
ir_write  out  1  latch IR and oldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  register-file write enable
result_src  out  2  00: ALUOut; 01: mem data; 10: ALU result direct
alu_src_a  out  2  00: PC; 01: oldPC; 10: rs1; 11: zero
alu_src_b  out  2  00: rs2; 01: imm; 10: constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
trap  out  1  illegal instruction; sticky
state_dbg  out  4  current state encoding

Behaviour:
- Reset: state = FETCH. On the reset cycle all write and strobe outputs are 0: pc_write, ir_write, reg_write, mem_write, mem_req, trap. All mux selects are 00 or 000. Reset overrides any state, including a pending memory wait.
- Outputs are Moore (state only), except three, which are gated combinationally by the inputs shown:
  - pc_write and ir_write in FETCH: gated by ready
  - pc_write in BRANCH: gated by the branch condition
  - mem_write in MEMWRITE: gated by mem_req
- Write "ready" for (mem_ready or MEM_HANDSHAKE == 0).
- States and transitions:
  - FETCH: mem_req = 1, adr_src = 0, a = 00, b = 10, add, result_src = 10; ir_write and pc_write = ready. Goes to DECODE when ready, otherwise stays in FETCH.
  - DECODE: a = 01, b = 01, add (branch/jal target into ALUOut); imm_src set from op. Next state by op:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100111 → JALR (when enabled)
    - 1100011 → BRANCH (funct3 legal per FULL_BRANCH)
    - 0110111 → LUI
    - anything else → TRAP
  - MEMADR: a = 10, b = 01, add. Goes to MEMREAD for loads, MEMWRITE for stores.
  - MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. Goes to MEMWB when ready, otherwise stays.
  - MEMWB: result_src = 01, reg_write = 1. Goes to FETCH.
  - MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. mem_write is held for every wait cycle. Goes to FETCH when ready.
  - EXECR: a = 10, b = 00. alu_control by funct3/funct7:
    - 000 with funct7 = 0 → add; 000 with funct7 = 1 → sub
    - 111 → and
    - 110 → or
    - 010 → slt
    - any other funct3 → TRAP
    - Legal cases go to ALUWB.
  - EXECI: a = 10, b = 01, same decode except funct3 000 is always add. Goes to ALUWB.
  - ALUWB: result_src = 00, reg_write = 1. Goes to FETCH.
  - JALR: a = 10, b = 01, imm_src = I, add (target into ALUOut). Goes to JAL.
  - JAL: result_src = 00, pc_write = 1, a = 01, b = 10, add (oldPC + 4). Goes to ALUWB.
  - BRANCH: a = 10, b = 00, sub, result_src = 00. pc_write = taken, where taken is:
    - beq: zero
    - bne: !zero
    - blt: alu_neg
    - bge: !alu_neg
    - Goes to FETCH.
  - LUI: a = 11, b = 01, imm_src = U, add. Goes to ALUWB.
  - TRAP: trap = 1, all strobes 0. Stays in TRAP until rst.
- Cycle counts with no wait states:
  - load: 5
  - store: 4
  - R/I-type: 4
  - lui: 4
  - jal: 4
  - jalr: 5
  - branch: 3
- Each wait cycle adds 1 cycle to FETCH, MEMREAD or MEMWRITE.

Test Plan:
- rst held high 2 cycles with mem_ready = 1 → state_dbg = FETCH; all strobes 0 during reset; first cycle after release: ir_write = 1, pc_write = 1.
- add (op 0110011, f3 000, f7 0) with mem_ready = 1 → FETCH, DECODE, EXECR (alu_control = 000), ALUWB (reg_write = 1), FETCH; 4 cycles; same sequence with f7 = 1 gives alu_control = 001.
- lw with mem_ready low for 3 cycles in MEMREAD → MEMREAD lasts 4 cycles with mem_req = 1 and adr_src = 1 throughout; MEMWB has result_src = 01 and reg_write = 1; with MEM_HANDSHAKE = 0 the same stall pattern gives 5 cycles total.
- beq with zero = 1 → pc_write = 1 in BRANCH; zero = 0 → pc_write = 0; bne, blt and bge checked against zero/alu_neg for both values.
- jalr with SUPPORT_JALR = 1 → DECODE, JALR, JAL (pc_write = 1), ALUWB; with SUPPORT_JALR = 0 → TRAP, trap = 1, stays in TRAP for 10 cycles, cleared by rst.
- sw with mem_ready arriving 2 cycles late, then rst asserted in the middle of a second FETCH wait → mem_write = 1 held for 3 cycles; rst returns the FSM to FETCH with all strobes 0 on the same edge.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and one memory port, with a ready stall and a sticky trap.
module riscv_multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_JALR  = 1'b1,
  parameter bit FULL_BRANCH   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       alu_neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       trap,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_JALR = 4'd9, S_JAL = 4'd10, S_BRANCH = 4'd11,
    S_LUI = 4'd12, S_TRAP = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                         OP_JAL  = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BR   = 7'b1100011, OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_SLT = 3'b101;

  state_t     state, nxt;
  logic       ready, alu_ok, br_ok, taken;
  logic [2:0] alu_rr, imm_dec;

  // Without the handshake every memory state is a single cycle.
  assign ready     = mem_ready | ~MEM_HANDSHAKE;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  always_comb begin
    alu_ok = 1'b1;
    alu_rr = ALU_ADD;
    case (funct3)
      3'b000:  alu_rr = funct7 ? ALU_SUB : ALU_ADD;
      3'b111:  alu_rr = ALU_AND;
      3'b110:  alu_rr = ALU_OR;
      3'b010:  alu_rr = ALU_SLT;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_ok = 1'b0;
    taken = 1'b0;
    case (funct3)
      3'b000:  begin br_ok = 1'b1;        taken = zero;     end
      3'b001:  begin br_ok = FULL_BRANCH; taken = ~zero;    end
      3'b100:  begin br_ok = FULL_BRANCH; taken = alu_neg;  end
      3'b101:  begin br_ok = FULL_BRANCH; taken = ~alu_neg; end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: imm_dec = 3'b001;
      OP_BR:    imm_dec = 3'b010;
      OP_JAL:   imm_dec = 3'b011;
      OP_LUI:   imm_dec = 3'b100;
      default:  imm_dec = 3'b000;
    endcase
  end

  always_comb begin
    nxt         = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = imm_dec;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
        if (ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jal target is precomputed into ALUOut here.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_R:    nxt = S_EXECR;
          OP_I:    nxt = S_EXECI;
          OP_JAL:  nxt = S_JAL;
          OP_JALR: nxt = SUPPORT_JALR ? S_JALR : S_TRAP;
          OP_BR:   nxt = br_ok ? S_BRANCH : S_TRAP;
          OP_LUI:  nxt = S_LUI;
          default: nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = mem_req;
        adr_src   = 1'b1;
        if (ready) nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_rr;
        nxt = alu_ok ? S_ALUWB : S_TRAP;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = (funct3 == 3'b000) ? ALU_ADD : alu_rr;
        nxt = alu_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = 3'b000;
        nxt       = S_JAL;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        nxt       = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = taken;
        nxt         = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        nxt       = S_ALUWB;
      end
      S_TRAP:  trap = 1'b1;
      default: nxt = S_FETCH;
    endcase
    // Reset silences every strobe and select in the cycle it is asserted.
    if (rst) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      imm_src     = 3'b000;
      trap        = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboarded bench: per-cycle expected state/outputs are queued as stimulus is
// driven and compared on the falling edge for the default and reduced configs.
module tb_riscv_multicycle_controller;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, JALR = 4'd9, JAL = 4'd10, BRANCH = 4'd11,
                         LUI = 4'd12, TRAP = 4'd13;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic       trap;
  } outs_t;

  typedef struct {
    string      tag;
    bit         sel;
    logic [3:0] st;
    outs_t      v;
    outs_t      m;
  } exp_t;

  logic clk = 1'b0;
  logic rst, funct7, zero, alu_neg, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [18:0] ov0, ov1;
  logic [3:0] sd0, sd1;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  riscv_multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .alu_neg(alu_neg), .mem_ready(mem_ready),
    .mem_req(ov0[18]), .mem_write(ov0[17]), .adr_src(ov0[16]), .ir_write(ov0[15]),
    .pc_write(ov0[14]), .reg_write(ov0[13]), .result_src(ov0[12:11]),
    .alu_src_a(ov0[10:9]), .alu_src_b(ov0[8:7]), .alu_control(ov0[6:4]),
    .imm_src(ov0[3:1]), .trap(ov0[0]), .state_dbg(sd0)
  );

  riscv_multicycle_controller #(.MEM_HANDSHAKE(1'b0), .SUPPORT_JALR(1'b0), .FULL_BRANCH(1'b0)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .alu_neg(alu_neg), .mem_ready(mem_ready),
    .mem_req(ov1[18]), .mem_write(ov1[17]), .adr_src(ov1[16]), .ir_write(ov1[15]),
    .pc_write(ov1[14]), .reg_write(ov1[13]), .result_src(ov1[12:11]),
    .alu_src_a(ov1[10:9]), .alu_src_b(ov1[8:7]), .alu_control(ov1[6:4]),
    .imm_src(ov1[3:1]), .trap(ov1[0]), .state_dbg(sd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a state, from the control table; unspecified selects masked.
  function automatic void model(input bit sel, input logic [3:0] st, output outs_t v, output outs_t m);
    logic rdy;
    rdy = mem_ready | sel;
    v = '0;
    m = '0;
    m.mem_req = 1; m.mem_write = 1; m.ir_write = 1; m.pc_write = 1; m.reg_write = 1; m.trap = 1;
    if (rst) begin
      m = '1;
    end else begin
      case (st)
        FETCH: begin
          v.mem_req = 1; v.ir_write = rdy; v.pc_write = rdy; v.alu_src_b = 2; v.result_src = 2;
          m.adr_src = 1; m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1; m.result_src = '1;
        end
        DECODE: begin
          v.alu_src_a = 1; v.alu_src_b = 1;
          m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1; m.imm_src = '1;
          case (op)
            7'b0100011: v.imm_src = 1;
            7'b1100011: v.imm_src = 2;
            7'b1101111: v.imm_src = 3;
            7'b0110111: v.imm_src = 4;
            7'b0000011, 7'b0010011, 7'b1100111: v.imm_src = 0;
            default: m.imm_src = 0;
          endcase
        end
        MEMADR: begin
          v.alu_src_a = 2; v.alu_src_b = 1;
          m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1;
        end
        MEMREAD: begin
          v.mem_req = 1; v.adr_src = 1; m.adr_src = 1; m.result_src = '1;
        end
        MEMWB: begin
          v.result_src = 1; v.reg_write = 1; m.result_src = '1;
        end
        MEMWRITE: begin
          v.mem_req = 1; v.mem_write = 1; v.adr_src = 1; m.adr_src = 1;
        end
        EXECR, EXECI: begin
          v.alu_src_a = 2; v.alu_src_b = (st == EXECI) ? 2'd1 : 2'd0;
          m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1;
          case (funct3)
            3'b000: v.alu_control = (st == EXECR && funct7) ? 3'b001 : 3'b000;
            3'b111: v.alu_control = 3'b010;
            3'b110: v.alu_control = 3'b011;
            3'b010: v.alu_control = 3'b101;
            default: m.alu_control = 0;
          endcase
        end
        ALUWB: begin
          v.reg_write = 1; m.result_src = '1;
        end
        JALR: begin
          v.alu_src_a = 2; v.alu_src_b = 1;
          m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1; m.imm_src = '1;
        end
        JAL: begin
          v.pc_write = 1; v.alu_src_a = 1; v.alu_src_b = 2;
          m.result_src = '1; m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1;
        end
        BRANCH: begin
          v.alu_src_a = 2; v.alu_control = 3'b001;
          m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1; m.result_src = '1;
          case (funct3)
            3'b000: v.pc_write = zero;
            3'b001: v.pc_write = ~zero;
            3'b100: v.pc_write = alu_neg;
            3'b101: v.pc_write = ~alu_neg;
            default: m.pc_write = 0;
          endcase
        end
        LUI: begin
          v.alu_src_a = 3; v.alu_src_b = 1; v.imm_src = 4;
          m.alu_src_a = '1; m.alu_src_b = '1; m.alu_control = '1; m.imm_src = '1;
        end
        TRAP: v.trap = 1;
        default: m = '0;
      endcase
    end
  endfunction

  task automatic push(input string tag, input bit sel, input logic [3:0] st);
    exp_t x;
    x.tag = tag; x.sel = sel; x.st = st;
    model(sel, st, x.v, x.m);
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input string tag, input bit sel, input logic [3:0] st);
    push(tag, sel, st);
    tick();
  endtask

  // States packed one nibble each, first state in the low nibble.
  task automatic seq(input string tag, input bit sel, input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) step($sformatf("%s.%0d", tag, i), sel, w[4*i +: 4]);
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".st"}, e.sel ? sd1 : sd0, e.st);
      chk({e.tag, ".out"}, (e.sel ? ov1 : ov0) & e.m, e.v);
    end
  end

  initial begin
    logic [2:0] rf3 [4];
    logic [2:0] bf3 [4];
    rf3 = '{3'b000, 3'b111, 3'b110, 3'b010};
    bf3 = '{3'b000, 3'b001, 3'b100, 3'b101};
    rst = 1; mem_ready = 1; zero = 0; alu_neg = 0;
    instr(7'b0110011, 3'b000, 1'b0);
    tick();
    push("rst0", 0, FETCH); push("rst0", 1, FETCH); tick();
    push("rst1", 0, FETCH); push("rst1", 1, FETCH); tick();
    rst = 0;

    // R-type add/sub/and/or/slt, then I-type
    seq("add", 0, 4, 32'h8610);
    instr(7'b0110011, 3'b000, 1'b1); seq("sub", 0, 4, 32'h8610);
    for (int i = 1; i < 4; i++) begin
      instr(7'b0110011, rf3[i], 1'b0); seq("rop", 0, 4, 32'h8610);
    end
    instr(7'b0010011, 3'b000, 1'b1); seq("addi", 0, 4, 32'h8710);
    instr(7'b0010011, 3'b110, 1'b0); seq("ori", 0, 4, 32'h8710);
    instr(7'b0110011, 3'b001, 1'b0); seq("rillg", 0, 4, 32'hD610);
    do_reset();

    // Load with 3 wait cycles in MEMREAD
    instr(7'b0000011, 3'b010, 1'b0);
    seq("lw", 0, 3, 32'h210);
    mem_ready = 0; seq("lw.w", 0, 3, 32'h333);
    mem_ready = 1; seq("lw.e", 0, 3, 32'h043);
    // Same stall pattern without the handshake
    do_reset();
    seq("lw2", 1, 3, 32'h210);
    mem_ready = 0; seq("lw2.e", 1, 3, 32'h043);
    mem_ready = 1;

    // Branches: every condition with both flag polarities
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int v = 0; v < 2; v++) begin
        zero = v[0]; alu_neg = ~v[0];
        instr(7'b1100011, bf3[i], 1'b0);
        seq($sformatf("br%0d_%0d", i, v), 0, 3, 32'hB10);
      end
    do_reset();
    zero = 1; instr(7'b1100011, 3'b000, 1'b0); seq("beq2", 1, 3, 32'hB10);
    instr(7'b1100011, 3'b001, 1'b0); seq("bne2", 1, 3, 32'hD10);

    // jalr, jal, lui, illegal opcode
    do_reset();
    instr(7'b1100111, 3'b000, 1'b0); seq("jalr", 0, 5, 32'h8A910);
    instr(7'b1101111, 3'b000, 1'b0); seq("jal", 0, 4, 32'h8A10);
    instr(7'b0110111, 3'b000, 1'b0); seq("lui", 0, 4, 32'h8C10);
    instr(7'b0000000, 3'b000, 1'b0); seq("illop", 0, 3, 32'hD10);
    do_reset();
    instr(7'b1100111, 3'b000, 1'b0); seq("jalr2", 1, 2, 32'h10);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      step($sformatf("trap%0d", i), 1, TRAP);
    end
    mem_ready = 1;
    rst = 1; step("trapclr", 1, TRAP);
    rst = 0; step("trapout", 1, FETCH);

    // Store with 2 late ready cycles, then reset during a FETCH wait
    do_reset();
    instr(7'b0100011, 3'b010, 1'b0);
    seq("sw", 0, 3, 32'h210);
    mem_ready = 0; seq("sw.w", 0, 2, 32'h55);
    mem_ready = 1; step("sw.e", 0, MEMWRITE);
    mem_ready = 0; seq("fw", 0, 2, 32'h00);
    rst = 1; step("fw.rst", 0, FETCH);
    rst = 0; mem_ready = 1; step("fw.after", 0, FETCH);

    @(negedge clk); #1;
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
